// File: rtl/sr_piso_param.sv
// sr_piso_param: parametrised PISO shift register with load/shift handshake,
// per-frame bit order and remaining-bit counter. Rev 1.0
`default_nettype none

module sr_piso_param #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             load_i,
   input  logic             msb_first_i,
   input  logic             shift_en_i,
   input  logic             sin_i,
   output logic             q_o,
   output logic [WIDTH-1:0] p_out_o,
   output logic             busy_o,
   output logic             load_ready_o,
   output logic             done_o,
   output logic [CW-1:0]    count_o
);

   localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             order_q, order_d;
   logic [CW-1:0]    count_q, count_d;
   logic             done_q,  done_d;

   logic w_busy;
   logic w_consume;
   logic w_last;
   logic w_accept;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         order_q <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         order_q <= order_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign w_busy    = (state_q == S_SHIFT);
   assign w_consume = w_busy && shift_en_i;
   assign w_last    = w_consume && (count_q == C_ONE);
   // Final-bit consume frees the register on the same edge, so a new word
   // can be accepted without a bubble.
   assign w_accept  = load_i && (!w_busy || w_last);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      order_d = order_q;
      count_d = count_q;
      done_d  = w_last;
      if (w_accept) begin
         state_d = S_SHIFT;
         shreg_d = d_i;
         order_d = msb_first_i;
         count_d = C_WIDTH;
      end else if (w_consume) begin
         if (order_q) begin
            shreg_d = {shreg_q[WIDTH-2:0], sin_i};
         end else begin
            shreg_d = {sin_i, shreg_q[WIDTH-1:1]};
         end
         count_d = count_q - C_ONE;
         if (w_last) begin
            state_d = S_IDLE;
         end
      end
   end

   assign q_o          = w_busy ? (order_q ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
   assign p_out_o      = shreg_q;
   assign busy_o       = w_busy;
   assign load_ready_o = !w_busy || w_last;
   assign done_o       = done_q;
   assign count_o      = count_q;

endmodule

`default_nettype wire
